// File: rtl/data_mem_responder.sv
// Multi-cycle data memory behind a valid/ready load/store port.
// Accepts one request at a time, waits LATENCY cycles, performs the RV32I
// byte/half/word access, then holds the response until it is taken.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW   = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT state, nextState;

  logic [CW-1:0] cnt;

  // latched request
  logic        latWe;
  logic [2:0]  latFunc3;
  logic [31:0] latAddr;
  logic [31:0] latWdata;

  // operands of the access actually being performed
  logic        accWe;
  logic [2:0]  accFunc3;
  logic [31:0] accAddr;
  logic [31:0] accWdata;

  logic            doAccess;
  logic            inRange;
  logic            accErr;
  logic [31:0]     accRdata;
  logic [31:0]     memWord;
  logic [31:0]     memWrWord;
  logic            memWrEn;
  logic [IDXW-1:0] memIdx;
  logic [29:0]     wordIdx;
  logic [1:0]      off;
  logic [7:0]      byteVal;
  logic [15:0]     halfVal;
  logic            legalF3;
  logic            misaligned;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // The access fires on the accept edge when LATENCY is 1, otherwise on the
  // WAIT edge where the counter has run out.
  assign doAccess = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                    ((state == WAIT) && (cnt == '0));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (req_valid) nextState = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == '0) nextState = RESP;
      RESP: if (resp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Single-cycle latency has no WAIT state, so the access must use the live
  // request inputs on the accept edge rather than the latched copy.
  always_comb begin
    if (LATENCY == 1) begin
      accWe    = req_we;
      accFunc3 = req_func3;
      accAddr  = req_addr;
      accWdata = req_wdata;
    end else begin
      accWe    = latWe;
      accFunc3 = latFunc3;
      accAddr  = latAddr;
      accWdata = latWdata;
    end
  end

  // Address decode and memory read
  always_comb begin
    wordIdx = accAddr[31:2];
    off     = accAddr[1:0];
    inRange = (32'(wordIdx) < DEPTH_WORDS);
    memIdx  = accAddr[IDXW+1:2];
    memWord = inRange ? mem[memIdx] : '0;
  end

  // Legality, alignment, load extraction and store merge
  always_comb begin
    legalF3    = 1'b0;
    misaligned = 1'b0;
    accRdata   = '0;
    memWrWord  = memWord;
    byteVal    = memWord[{off, 3'b000} +: 8];
    halfVal    = off[1] ? memWord[31:16] : memWord[15:0];

    if (accWe) begin
      legalF3 = (accFunc3 == 3'b000) || (accFunc3 == 3'b001) || (accFunc3 == 3'b010);
    end else begin
      legalF3 = (accFunc3 == 3'b000) || (accFunc3 == 3'b001) || (accFunc3 == 3'b010) ||
                (accFunc3 == 3'b100) || (accFunc3 == 3'b101);
    end

    case (accFunc3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase

    accErr = !legalF3 || misaligned || !inRange;

    if (!accWe && !accErr) begin
      case (accFunc3)
        3'b000:  accRdata = {{24{byteVal[7]}}, byteVal};
        3'b100:  accRdata = {24'b0, byteVal};
        3'b001:  accRdata = {{16{halfVal[15]}}, halfVal};
        3'b101:  accRdata = {16'b0, halfVal};
        3'b010:  accRdata = memWord;
        default: accRdata = '0;
      endcase
    end

    case (accFunc3[1:0])
      2'b00: memWrWord[{off, 3'b000} +: 8] = accWdata[7:0];
      2'b01: begin
        if (off[1]) memWrWord[31:16] = accWdata[15:0];
        else        memWrWord[15:0]  = accWdata[15:0];
      end
      default: memWrWord = accWdata;
    endcase

    // reset held low must block any commit, even on a clock edge
    memWrEn = doAccess && accWe && !accErr && rst;
  end

  // Request latch, wait counter and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      latWe      <= 1'b0;
      latFunc3   <= '0;
      latAddr    <= '0;
      latWdata   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        latWe    <= req_we;
        latFunc3 <= req_func3;
        latAddr  <= req_addr;
        latWdata <= req_wdata;
        cnt      <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (doAccess) begin
        resp_rdata <= accRdata;
        resp_err   <= accErr;
      end else if ((state == RESP) && resp_ready) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Storage write port; contents survive reset
  always_ff @(posedge clk) begin
    if (memWrEn) begin
      mem[memIdx] <= memWrWord;
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data memory that serves the pipeline's load/store port through valid/ready handshakes.
- Replaces the single-cycle combinational data memory when the M stage is made stall-capable.
- Accepts one request at a time, waits a fixed number of cycles, performs the RV32I byte/half/word access, then holds the response until the requester takes it.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage; word index is addr[31:2].
- LATENCY, 2, cycles from the request-accept edge to the first cycle resp_valid is high; legal range is 1 or more.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted while 0.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I func3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SB uses [7:0], SH uses [15:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and for errors.
- resp_err  out  1  request was misaligned, out of range, or used an illegal func3.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset: state goes to IDLE. resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1, counter=0. Memory contents are not cleared.
- Reset during WAIT or RESP aborts the transaction. A store whose commit edge has not yet occurred is never written.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch we, func3, addr and wdata.
  - If LATENCY>1: load counter with LATENCY-2 and go to WAIT.
  - If LATENCY=1: perform the access on this same edge and go to RESP.
- WAIT:
  - req_ready=0; request inputs are ignored.
  - While counter is not 0, decrement it each edge.
  - On the edge where counter is 0, perform the access, register resp_rdata and resp_err, and go to RESP.
- Timing: if a request is accepted at edge T, resp_valid is high from edge T+LATENCY.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On an edge with resp_ready=1, go to IDLE and clear resp_valid, resp_rdata and resp_err to 0.
  - A new request cannot be accepted in the same cycle as the response handshake. Minimum spacing between accepts is LATENCY+1 cycles.
- Access rules (little-endian, byte lane = addr[1:0]):
  - LB / LBU: selected byte, sign- or zero-extended to 32 bits.
  - LH / LHU: halfword at addr[1]; sign- or zero-extended.
  - LW: full word.
  - SB: writes one byte lane only.
  - SH: writes one halfword only.
  - SW: writes the whole word. Unselected lanes are preserved.
- Error conditions; each sets resp_err=1, resp_rdata=0, and performs no write:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0] not 00.
  - addr[31:2] greater than or equal to DEPTH_WORDS.
  - Load func3 011, 110 or 111.
  - Store func3 other than 000, 001 or 010.
- Request inputs need only be stable at the accept edge. The latched copy is used for the access.

Test Plan:
- Reset then word round-trip, LATENCY=2: rst low then high; SW addr 0x10 data 0xDEADBEEF accepted at T → resp_valid rises at T+2 with resp_err=0, resp_rdata=0. Then LW addr 0x10 → resp_rdata=0xDEADBEEF.
- Byte and halfword lanes: SW 0x20 with 0x11223344, then SB 0x21 with 0xAA → LW 0x20 returns 0x1122AA44. LB 0x21 returns 0xFFFFFFAA, LBU 0x21 returns 0x000000AA, LH 0x22 returns 0x00001122, LHU 0x20 returns 0x0000AA44.
- Errors:
  - LW at 0x13 → resp_err=1, rdata=0.
  - SH at 0x21 with 0xBEEF → resp_err=1, and a following LW 0x20 still returns 0x1122AA44.
  - LW at byte address 4*DEPTH_WORDS → resp_err=1.
  - Load with func3 011 → resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stay constant and req_ready stays 0 throughout. Raise resp_ready → IDLE next cycle with req_ready=1 and resp_valid=0.
- LATENCY=1 build: request accepted at T → resp_valid at T+1. Back-to-back requests with req_valid held high are accepted every 2 cycles.
- Reset mid-operation: accept SW 0x30 with 0x55555555 at T, pull rst low during WAIT, release it, then LW 0x30 → returns the pre-existing value, not 0x55555555. Outputs read 0 while rst is low.
